sim_uart_monitor: RTL and testbench

Parametrised serial-line receiver and watchdog for the SoC simulation bench. It watches the DUT's UART TX line and decodes frames with configurable baud divisor, data width, parity and stop bits. Each good character is reported as a one-cycle strobe, and framing and parity errors are flagged. An idle watchdog lets the bench end a run on firmware output or on silence instead of a fixed delay.

---
 rtl/sim_uart_pkg.sv | 23 ++
 rtl/sim_uart_sync.sv | 38 +++
 rtl/sim_uart_monitor.sv | 239 +++++++++++++++++++++++
 tb/tb_sim_uart_monitor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the simulation UART monitor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sim_uart_pkg;

    // Receive FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Parity modes for the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Width of the good-character counter.
    localparam int BYTE_CNT_W = 16;

endpackage

// File: rtl/sim_uart_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the synchronised value.
// Latency: falling edge visible two clkin cycles after rx is first sampled low.
// Backpressure: none; free-running on every clkin edge.
//
// Ports:
//   clkin     - clock, rising edge
//   rst_n     - synchronous active-low reset (all flops reset to 1 = idle line)
//   i_rx      - asynchronous serial input
//   o_rx_sync - synchronised line value
//   o_fall    - high for one cycle when the synchronised line goes 1 -> 0
module sim_uart_sync (
    input  logic clkin,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_rx_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rx_sync = r_sync;
    assign o_fall    = r_prev & ~r_sync;

endmodule

// File: rtl/sim_uart_monitor.sv
// Serial-line receiver and idle watchdog for the simulation bench (optional printing via SIM_UART_MONITOR_PRINT_EN).
// Latency: result strobe one cycle after the last stop-bit sample.
// Backpressure: none; results are one-cycle pulses that the consumer must catch.
//
// Ports:
//   clkin, rst_n   - clock and synchronous active-low reset
//   rx             - serial line, idle high, asynchronous
//   data_o         - last good character
//   valid_o        - one-cycle pulse, good character on data_o
//   frame_err_o    - one-cycle pulse, a stop bit sampled low
//   parity_err_o   - one-cycle pulse, parity mismatch
//   busy_o         - frame in progress
//   timeout_o      - sticky, idle watchdog expired
//   byte_count_o   - saturating count of good characters
module sim_uart_monitor
    import sim_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT   = 868,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [DATA_BITS-1:0]  data_o,
    output logic                  valid_o,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [BYTE_CNT_W-1:0] byte_count_o
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_bitcnt;
    logic [3:0]            r_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_ferr_l;
    logic                  r_perr_l;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid;
    logic                  r_ferr_p;
    logic                  r_perr_p;
    logic [BYTE_CNT_W-1:0] r_count;
    logic [31:0]           r_wd;
    logic                  r_timeout;

    logic w_rx;
    logic w_fall;
    logic w_tick;
    logic w_last_data;
    logic w_last_stop;
    logic w_done;
    logic w_ferr_now;
    logic w_good;
    logic w_exp_par;
    logic w_busy;

    sim_uart_sync u_sync (
        .clkin     (clkin),
        .rst_n     (rst_n),
        .i_rx      (rx),
        .o_rx_sync (w_rx),
        .o_fall    (w_fall)
    );

    assign w_tick      = (r_bitcnt == '0);
    assign w_last_data = (r_idx == 4'(DATA_BITS - 1));
    assign w_last_stop = (r_idx == 4'(STOP_BITS - 1));
    assign w_done      = (r_state == STOP) && w_tick && w_last_stop;
    // Framing error includes the stop sample being taken this very cycle.
    assign w_ferr_now  = r_ferr_l | ~w_rx;
    assign w_good      = w_done & ~w_ferr_now & ~r_perr_l;
    assign w_exp_par   = (PARITY == PAR_ODD) ? ~(^r_shift) : (^r_shift);

    // State register.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fall) w_state_nxt = START;
            // A high start sample is a glitch: drop back silently.
            START:   if (w_tick) w_state_nxt = w_rx ? IDLE : DATA;
            DATA:    if (w_tick && w_last_data) w_state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
            PAR:     if (w_tick) w_state_nxt = STOP;
            STOP:    if (w_tick && w_last_stop) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        w_busy = (r_state != IDLE);
    end

    // Bit timing, shift register and result strobes.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_ferr_l <= 1'b0;
            r_perr_l <= 1'b0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr_p <= 1'b0;
            r_perr_p <= 1'b0;
            r_count  <= '0;
        end else begin
            r_valid  <= 1'b0;
            r_ferr_p <= 1'b0;
            r_perr_p <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        // Half a bit minus one lands the start sample mid-bit.
                        r_bitcnt <= CW'(CLKS_PER_BIT / 2 - 1);
                        r_idx    <= '0;
                        r_ferr_l <= 1'b0;
                        r_perr_l <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_bitcnt <= CW'(CLKS_PER_BIT - 1);
                        r_idx    <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_bitcnt <= CW'(CLKS_PER_BIT - 1);
                        r_shift  <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_idx    <= w_last_data ? 4'd0 : r_idx + 4'd1;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                PAR: begin
                    if (w_tick) begin
                        r_bitcnt <= CW'(CLKS_PER_BIT - 1);
                        r_perr_l <= (w_rx != w_exp_par);
                        r_idx    <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_bitcnt <= CW'(CLKS_PER_BIT - 1);
                        r_idx    <= r_idx + 4'd1;
                        r_ferr_l <= w_ferr_now;
                        if (w_last_stop) begin
                            if (w_good) begin
                                r_data  <= r_shift;
                                r_valid <= 1'b1;
                                if (r_count != {BYTE_CNT_W{1'b1}}) begin
                                    r_count <= r_count + 1'b1;
                                end
                            end else begin
                                r_ferr_p <= w_ferr_now;
                                r_perr_p <= r_perr_l;
                            end
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                default: r_bitcnt <= '0;
            endcase
        end
    end

    // Idle watchdog. The cycle in which valid_o is high is the first idle
    // cycle counted, so timeout_o rises TIMEOUT_CYCLES cycles after valid_o.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_wd      <= '0;
            r_timeout <= 1'b0;
        end else if (TIMEOUT_CYCLES != 0) begin
            if (w_busy || w_good) begin
                r_wd <= '0;
            end else begin
                if (r_wd != 32'(TIMEOUT_CYCLES)) begin
                    r_wd <= r_wd + 32'd1;
                end
                if (r_wd == 32'(TIMEOUT_CYCLES - 1)) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_ferr_p;
    assign parity_err_o = r_perr_p;
    assign busy_o       = w_busy;
    assign timeout_o    = r_timeout;
    assign byte_count_o = r_count;

`ifdef SIM_UART_MONITOR_PRINT_EN
    logic r_timeout_d;

    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            r_timeout_d <= 1'b0;
        end else begin
            r_timeout_d <= r_timeout;
            if (r_valid) begin
                $write("%c", data_o);
            end
            if (r_ferr_p || r_perr_p) begin
                $display("sim_uart_monitor warning: frame_err=%0b parity_err=%0b at %0t",
                         r_ferr_p, r_perr_p, $time);
            end
            if (r_timeout && !r_timeout_d) begin
                $display("UART timeout");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_sim_uart_monitor.sv
// Bench for sim_uart_monitor: two instances (8N1 with watchdog, 8E1 without).
// Latency: events are stamped with the first clock edge that can see them.
// Backpressure: n/a.
module tb_sim_uart_monitor;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        rx_a, rx_b;
    logic [7:0]  a_data, b_data;
    logic        a_valid, b_valid, a_ferr, b_ferr, a_perr, b_perr;
    logic        a_busy, b_busy, a_to, b_to;
    logic [15:0] a_cnt, b_cnt;

    sim_uart_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                       .TIMEOUT_CYCLES(1000)) u_a (
        .clkin(clk), .rst_n(rst_n), .rx(rx_a), .data_o(a_data), .valid_o(a_valid),
        .frame_err_o(a_ferr), .parity_err_o(a_perr), .busy_o(a_busy),
        .timeout_o(a_to), .byte_count_o(a_cnt));

    sim_uart_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                       .TIMEOUT_CYCLES(0)) u_b (
        .clkin(clk), .rst_n(rst_n), .rx(rx_b), .data_o(b_data), .valid_o(b_valid),
        .frame_err_o(b_ferr), .parity_err_o(b_perr), .busy_o(b_busy),
        .timeout_o(b_to), .byte_count_o(b_cnt));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event = (edge << 16) | (kind << 8) | data; kind 1 good, 2 framing, 3 parity.
    function automatic longint ev(input int t, input int k, input int d);
        return (longint'(t) << 16) | longint'(k << 8) | longint'(d & 255);
    endfunction

    longint obs_a[$], obs_b[$], exp_a[$], exp_b[$];
    int     exp_cnt[2];
    int     exp_last[2];
    int     a_busy_cyc = 0;
    int     a_to_t = -1;
    logic   a_to_q = 1'b0;

    // Observed-event collector, sampled mid-cycle.
    always @(negedge clk) begin
        if (a_valid) obs_a.push_back(ev(cyc + 1, 1, int'(a_data)));
        if (a_ferr)  obs_a.push_back(ev(cyc + 1, 2, 0));
        if (a_perr)  obs_a.push_back(ev(cyc + 1, 3, 0));
        if (b_valid) obs_b.push_back(ev(cyc + 1, 1, int'(b_data)));
        if (b_ferr)  obs_b.push_back(ev(cyc + 1, 2, 0));
        if (b_perr)  obs_b.push_back(ev(cyc + 1, 3, 0));
        if (a_busy)  a_busy_cyc++;
        if (a_to && !a_to_q) a_to_t = cyc + 1;
        a_to_q = a_to;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx_a = v;
        else        rx_b = v;
    endtask

    // Reference model: a frame's outcome follows from its bits alone; the
    // result appears half a bit plus N bit periods plus 3 edges after t0.
    task automatic send(input int d, input int dat, input bit bad_par, input bit bad_stop,
                        input int gap);
        logic [10:0] bits;
        logic [7:0]  b8;
        int          nb, t0, fire;
        b8        = dat[7:0];
        bits      = '0;
        bits[8:1] = b8;
        if (d == 0) begin
            nb      = 10;
            bits[9] = !bad_stop;
        end else begin
            nb       = 11;
            bits[9]  = (^b8) ^ bad_par;
            bits[10] = !bad_stop;
        end
        t0   = cyc + 1;
        fire = t0 + 3 + CPB / 2 + (nb - 1) * CPB;
        if (!bad_par && !bad_stop) begin
            if (d == 0) exp_a.push_back(ev(fire, 1, dat));
            else        exp_b.push_back(ev(fire, 1, dat));
            exp_cnt[d]++;
            exp_last[d] = dat & 255;
        end else begin
            if (bad_stop) begin
                if (d == 0) exp_a.push_back(ev(fire, 2, 0));
                else        exp_b.push_back(ev(fire, 2, 0));
            end
            if (bad_par) exp_b.push_back(ev(fire, 3, 0));
        end
        for (int i = 0; i < nb; i++) begin
            set_rx(d, bits[i]);
            step(CPB);
        end
        set_rx(d, 1'b1);
        step(gap * CPB);
    endtask

    task automatic verify(input string tag, input int d);
        longint o[$];
        longint e[$];
        int     n;
        if (d == 0) begin
            o = obs_a; e = exp_a;
        end else begin
            o = obs_b; e = exp_b;
        end
        chk({tag, "_nev"}, 64'(o.size()), 64'(e.size()));
        n = (o.size() < e.size()) ? o.size() : e.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), o[i], e[i]);
        if (d == 0) begin
            chk({tag, "_cnt"}, 64'(a_cnt), 64'(exp_cnt[0]));
            obs_a.delete(); exp_a.delete();
        end else begin
            chk({tag, "_cnt"}, 64'(b_cnt), 64'(exp_cnt[1]));
            obs_b.delete(); exp_b.delete();
        end
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_data"},  64'(a_data),  0);
        chk({tag, "_valid"}, 64'(a_valid), 0);
        chk({tag, "_ferr"},  64'(a_ferr),  0);
        chk({tag, "_perr"},  64'(a_perr),  0);
        chk({tag, "_busy"},  64'(a_busy),  0);
        chk({tag, "_to"},    64'(a_to),    0);
        chk({tag, "_cnt"},   64'(a_cnt),   0);
    endtask

    initial begin
        int t0;
        int dat;
        bit bs, bp;
        exp_cnt[0]  = 0; exp_cnt[1]  = 0;
        exp_last[0] = 0; exp_last[1] = 0;
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        step(5);
        chk_zero_a("rst_a");
        chk("rst_b_busy", 64'(b_busy), 0);
        chk("rst_b_cnt",  64'(b_cnt),  0);
        chk("rst_b_data", 64'(b_data), 0);
        rst_n = 1'b1;
        step(2);
        obs_a.delete(); obs_b.delete();

        // Single character, then idle into the watchdog.
        t0 = cyc + 1;
        send(0, 'h55, 0, 0, 0);
        chk("first_data", 64'(a_data), 'h55);
        verify("first", 0);
        chk("to_early", 64'(a_to), 0);
        step(1100);
        chk("to_set", 64'(a_to), 1);
        chk("to_time", 64'(a_to_t), 64'(t0 + 3 + CPB / 2 + 9 * CPB + 1000));

        // Reset in the middle of a frame.
        rx_a = 1'b0;
        step(40);
        chk("mid_busy", 64'(a_busy), 1);
        rst_n = 1'b0;
        step(1);
        chk_zero_a("mid_rst");
        rx_a = 1'b1;
        step(4);
        rst_n = 1'b1;
        step(2);
        obs_a.delete(); exp_a.delete();
        exp_cnt[0] = 0;
        exp_last[0] = 0;

        // Back-to-back "OK\n".
        send(0, 'h4F, 0, 0, 0);
        send(0, 'h4B, 0, 0, 0);
        send(0, 'h0A, 0, 0, 2);
        verify("okn", 0);
        chk("okn_last", 64'(a_data), 'h0A);

        // Random characters with occasional bad stop bits.
        for (int i = 0; i < 8; i++) begin
            dat = int'($urandom_range(255));
            bs  = ($urandom_range(3) == 0);
            send(0, dat, 0, bs, bs ? 2 : int'($urandom_range(1)));
        end
        step(CPB);
        verify("rand_a", 0);

        // Break: line low for 20 bit times.
        t0   = cyc + 1;
        rx_a = 1'b0;
        step(20 * CPB);
        rx_a = 1'b1;
        step(2 * CPB);
        exp_a.push_back(ev(t0 + 3 + CPB / 2 + 9 * CPB, 2, 0));
        verify("break", 0);
        chk("break_hold", 64'(a_data), 64'(exp_last[0]));
        send(0, 'h41, 0, 0, 2);
        verify("after_break", 0);
        chk("after_break_data", 64'(a_data), 'h41);

        // Short glitch.
        a_busy_cyc = 0;
        rx_a = 1'b0;
        step(4);
        rx_a = 1'b1;
        step(3 * CPB);
        chk("glitch_busy_le10", 64'(a_busy_cyc <= 10), 1);
        chk("glitch_busy_seen", 64'(a_busy_cyc > 0), 1);
        chk("glitch_idle", 64'(a_busy), 0);
        verify("glitch", 0);

        // Even parity instance.
        send(1, 'hA3, 1, 0, 2);
        verify("par_bad", 1);
        send(1, 'hA3, 0, 0, 2);
        verify("par_good", 1);
        chk("par_good_data", 64'(b_data), 'hA3);
        for (int i = 0; i < 8; i++) begin
            dat = int'($urandom_range(255));
            bp  = ($urandom_range(2) == 0);
            bs  = ($urandom_range(4) == 0);
            send(1, dat, bp, bs, bs ? 2 : int'($urandom_range(1)));
        end
        step(CPB);
        verify("rand_b", 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
